// File: rtl/eq_pkg.sv
// Shared types and A2D channel map for the equalizer pot scanner.
// Slots follow pot order LP, B1, B2, B3, HP, VOL.
package eq_pkg;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, NEXT} scan_state_t;

   typedef logic [2:0] slot_t;

   localparam logic [2:0] CH_LP  = 3'd1;
   localparam logic [2:0] CH_B1  = 3'd0;
   localparam logic [2:0] CH_B2  = 3'd4;
   localparam logic [2:0] CH_B3  = 3'd2;
   localparam logic [2:0] CH_HP  = 3'd3;
   localparam logic [2:0] CH_VOL = 3'd7;

   localparam int    NUM_SLOTS = 6;
   localparam slot_t LAST_SLOT = 3'd5;

   localparam logic [2:0] CHAN_MAP [0:5] = '{CH_LP, CH_B1, CH_B2, CH_B3, CH_HP, CH_VOL};

   // Slot values 6 and 7 never occur; they fall back to the first channel.
   function automatic logic [2:0] slot_chan(input slot_t slot);
      case (slot)
         3'd0:    return CHAN_MAP[0];
         3'd1:    return CHAN_MAP[1];
         3'd2:    return CHAN_MAP[2];
         3'd3:    return CHAN_MAP[3];
         3'd4:    return CHAN_MAP[4];
         3'd5:    return CHAN_MAP[5];
         default: return CHAN_MAP[0];
      endcase
   endfunction

endpackage

// File: rtl/pot_scan_sched_timer.sv
// Saturating up-counter with synchronous clear. Reset loads a preset so a
// timer can start out already expired.
module scan_timer #(
   parameter int unsigned MAX     = 15,
   parameter int unsigned RST_VAL = 0,
   parameter int unsigned W       = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] MAX_C = W'(MAX);
   localparam logic [W-1:0] RST_C = W'(RST_VAL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= RST_C;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != MAX_C)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pot_scan_sched.sv
// Round-robin A2D scheduler for the six slide pots: requests one conversion per
// slot, latches results into gain/volume registers and flags A2D timeouts.
module pot_scan_sched
   import eq_pkg::*;
#(
   parameter int unsigned SWEEP_GAP = 4096,
   parameter int unsigned TIMEOUT   = 2048,
   parameter logic [11:0] RST_GAIN  = 12'h800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic        strt_cnv,
   output logic [2:0]  cnv_chnl,
   input  logic        cnv_cmplt,
   input  logic [11:0] res,
   output logic [11:0] gain_lp,
   output logic [11:0] gain_b1,
   output logic [11:0] gain_b2,
   output logic [11:0] gain_b3,
   output logic [11:0] gain_hp,
   output logic [11:0] volume,
   output logic        sweep_done,
   output logic        to_err,
   output logic [2:0]  to_chnl
);

   localparam int unsigned TO_MAX = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam int unsigned GAP_W  = (SWEEP_GAP < 1) ? 1 : $clog2(SWEEP_GAP + 1);
   localparam int unsigned TO_W   = (TO_MAX < 1) ? 1 : $clog2(TO_MAX + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_MAX);

   scan_state_t      state;
   scan_state_t      state_nxt;
   slot_t            slot;
   logic [GAP_W-1:0] gap_cnt;
   logic [TO_W-1:0]  to_cnt;
   logic [11:0]      gain_q [0:NUM_SLOTS-1];
   logic             gap_ok;
   logic             to_hit;
   logic             last_slot;
   logic             store;
   logic             timeout;

   // The gap timer is preset to SWEEP_GAP so the very first sweep starts at once.
   scan_timer #(.MAX(SWEEP_GAP), .RST_VAL(SWEEP_GAP), .W(GAP_W)) u_gap_timer (
      .clk   (clk),
      .rst   (rst),
      .clr   ((state == NEXT) && last_slot),
      .inc   (state == IDLE),
      .count (gap_cnt)
   );

   scan_timer #(.MAX(TO_MAX), .RST_VAL(0), .W(TO_W)) u_to_timer (
      .clk   (clk),
      .rst   (rst),
      .clr   (state == REQ),
      .inc   (state == WAIT),
      .count (to_cnt)
   );

   // Counting the current idle cycle makes the gap exactly SWEEP_GAP idle cycles.
   assign gap_ok    = (32'(gap_cnt) + 32'd1) >= SWEEP_GAP;
   assign to_hit    = (to_cnt == TO_LAST);
   assign last_slot = (slot == LAST_SLOT);
   assign cnv_chnl  = slot_chan(slot);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en && gap_ok) state_nxt = REQ;
         REQ:     state_nxt = WAIT;
         WAIT:    if (cnv_cmplt || to_hit) state_nxt = NEXT;
         NEXT:    state_nxt = (!last_slot && en) ? REQ : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A completion arriving on the timeout cycle wins over the timeout.
   always_comb begin
      strt_cnv   = 1'b0;
      sweep_done = 1'b0;
      store      = 1'b0;
      timeout    = 1'b0;
      case (state)
         REQ:  strt_cnv = 1'b1;
         WAIT: begin
            store   = cnv_cmplt;
            timeout = !cnv_cmplt && to_hit;
         end
         NEXT: sweep_done = last_slot;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot    <= '0;
         to_err  <= 1'b0;
         to_chnl <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            gain_q[i] <= RST_GAIN;
         end
      end else begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (store && (slot == slot_t'(i))) gain_q[i] <= res;
         end
         if (timeout) begin
            to_err  <= 1'b1;
            to_chnl <= cnv_chnl;
         end
         if (state == NEXT) slot <= last_slot ? '0 : slot + 3'd1;
      end
   end

   assign gain_lp = gain_q[0];
   assign gain_b1 = gain_q[1];
   assign gain_b2 = gain_q[2];
   assign gain_b3 = gain_q[3];
   assign gain_hp = gain_q[4];
   assign volume  = gain_q[5];

endmodule

// File: tb/tb_pot_scan_sched.sv
// Bench for pot_scan_sched: an A2D responder with random latency and data,
// checked against a pot-order reference model of gains and timeout state.
module tb_pot_scan_sched;

   localparam int unsigned GAP = 50;
   localparam int unsigned TMO = 64;
   localparam logic [2:0] POT_CH [0:5] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        strt_cnv;
   logic [2:0]  cnv_chnl;
   logic        cnv_cmplt;
   logic [11:0] res;
   logic [11:0] gain_lp, gain_b1, gain_b2, gain_b3, gain_hp, volume;
   logic        sweep_done;
   logic        to_err;
   logic [2:0]  to_chnl;

   logic        strt0, cmplt0, sweep0, to_err0;
   logic [2:0]  chnl0, to_chnl0;
   logic [11:0] res0;
   logic [11:0] g0_lp, g0_b1, g0_b2, g0_b3, g0_hp, g0_vol;

   int vectors     = 0;
   int miscompares = 0;

   logic [11:0] exp_gain [0:5];
   int          exp_slot;
   bit          exp_to_err;
   logic [2:0]  exp_to_chnl;

   pot_scan_sched #(.SWEEP_GAP(GAP), .TIMEOUT(TMO), .RST_GAIN(12'h800)) dut (
      .clk(clk), .rst(rst), .en(en), .strt_cnv(strt_cnv), .cnv_chnl(cnv_chnl),
      .cnv_cmplt(cnv_cmplt), .res(res), .gain_lp(gain_lp), .gain_b1(gain_b1),
      .gain_b2(gain_b2), .gain_b3(gain_b3), .gain_hp(gain_hp), .volume(volume),
      .sweep_done(sweep_done), .to_err(to_err), .to_chnl(to_chnl)
   );

   // Second instance with no sweep gap, answered by its own instant responder.
   pot_scan_sched #(.SWEEP_GAP(0), .TIMEOUT(TMO), .RST_GAIN(12'h800)) dut0 (
      .clk(clk), .rst(rst), .en(1'b1), .strt_cnv(strt0), .cnv_chnl(chnl0),
      .cnv_cmplt(cmplt0), .res(res0), .gain_lp(g0_lp), .gain_b1(g0_b1),
      .gain_b2(g0_b2), .gain_b3(g0_b3), .gain_hp(g0_hp), .volume(g0_vol),
      .sweep_done(sweep0), .to_err(to_err0), .to_chnl(to_chnl0)
   );

   always #5 clk = ~clk;

   initial begin
      cmplt0 = 1'b0;
      res0   = '0;
      forever begin
         @(negedge clk);
         cmplt0 = 1'b0;
         if (strt0 === 1'b1) begin
            @(negedge clk);
            cmplt0 = 1'b1;
            res0   = 12'($urandom);
         end
      end
   end

   function automatic logic [11:0] dut_gain(input int s);
      case (s)
         0:       return gain_lp;
         1:       return gain_b1;
         2:       return gain_b2;
         3:       return gain_b3;
         4:       return gain_hp;
         default: return volume;
      endcase
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 6; i++) exp_gain[i] = 12'h800;
      exp_slot    = 0;
      exp_to_err  = 1'b0;
      exp_to_chnl = 3'd0;
   endfunction

   // Resolves the current slot; returns 1 when it was the last pot of a sweep.
   function automatic bit model_resolve(input bit answered, input logic [11:0] v);
      bit last;
      if (answered) begin
         exp_gain[exp_slot] = v;
      end else begin
         exp_to_err  = 1'b1;
         exp_to_chnl = POT_CH[exp_slot];
      end
      last     = (exp_slot == 5);
      exp_slot = (exp_slot + 1) % 6;
      return last;
   endfunction

   task automatic apply_reset();
      en        = 1'b0;
      cnv_cmplt = 1'b0;
      rst       = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // Returns at the negedge of the request cycle, or after budget cycles.
   task automatic wait_req(input int budget, output bit seen, output logic [2:0] ch,
                           output int waited);
      seen   = 1'b0;
      ch     = 3'd0;
      waited = budget;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (strt_cnv === 1'b1) begin
            seen   = 1'b1;
            ch     = cnv_chnl;
            waited = i;
            break;
         end
      end
   endtask

   // From the request cycle, answer d cycles later (d = 0: stay silent);
   // returns at the negedge of the resolving cycle.
   task automatic respond(input int d, input logic [11:0] v, output bit stable);
      logic [11:0] snap [0:5];
      int n;
      for (int s = 0; s < 6; s++) snap[s] = dut_gain(s);
      stable = 1'b1;
      n = (d == 0) ? int'(TMO) + 1 : d;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         for (int s = 0; s < 6; s++) if (dut_gain(s) !== snap[s]) stable = 1'b0;
      end
      if (d != 0) begin
         cnv_cmplt = 1'b1;
         res       = v;
         @(negedge clk);
         cnv_cmplt = 1'b0;
         res       = 12'($urandom);
      end
   endtask

   task automatic test_reset();
      int starts;
      en = 1'b0; cnv_cmplt = 1'b0; res = '0; rst = 1'b1;
      repeat (2) @(negedge clk);
      model_reset();
      vectors++;
      if (strt_cnv !== 1'b0 || sweep_done !== 1'b0 || to_err !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_flags: got strt=%b done=%b to_err=%b, expected 0 0 0",
                  strt_cnv, sweep_done, to_err);
      end
      vectors++;
      if (cnv_chnl !== 3'd1 || to_chnl !== 3'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_chnl: got cnv_chnl=%0d to_chnl=%0d, expected 1 0",
                  cnv_chnl, to_chnl);
      end
      for (int s = 0; s < 6; s++) begin
         vectors++;
         if (dut_gain(s) !== exp_gain[s]) begin
            miscompares++;
            $display("[TB] FAIL reset_gain[%0d]: got %h expected %h", s, dut_gain(s), exp_gain[s]);
         end
      end
      rst = 1'b0;
      starts = 0;
      repeat (6) begin
         @(negedge clk);
         if (strt_cnv === 1'b1) starts++;
      end
      vectors++;
      if (starts != 0) begin
         miscompares++;
         $display("[TB] FAIL reset_idle_hold: got %0d requests with en=0, expected 0", starts);
      end
   endtask

   task automatic test_sweep();
      bit seen, stable, last;
      logic [2:0] ch;
      logic [11:0] v;
      int waited, dones;
      apply_reset();
      en = 1'b1;
      dones = 0;
      for (int s = 0; s < 6; s++) begin
         wait_req(4, seen, ch, waited);
         vectors++;
         if (!seen || ch !== POT_CH[s] || waited != 0) begin
            miscompares++;
            $display("[TB] FAIL sweep_req[%0d]: got seen=%b chnl=%0d wait=%0d, expected chnl=%0d wait=0",
                     s, seen, ch, waited, POT_CH[s]);
            return;
         end
         v = 12'(POT_CH[s]) * 12'h111;
         respond(40, v, stable);
         last = model_resolve(1'b1, v);
         vectors++;
         if (!stable || sweep_done !== last) begin
            miscompares++;
            $display("[TB] FAIL sweep_slot[%0d]: got stable=%b done=%b, expected 1 %b",
                     s, stable, sweep_done, last);
         end
         if (sweep_done === 1'b1) dones++;
      end
      vectors++;
      if (gain_b3 !== 12'h222 || volume !== 12'h777) begin
         miscompares++;
         $display("[TB] FAIL sweep_values: got b3=%h vol=%h, expected 222 777", gain_b3, volume);
      end
      for (int s = 0; s < 6; s++) begin
         vectors++;
         if (dut_gain(s) !== exp_gain[s]) begin
            miscompares++;
            $display("[TB] FAIL sweep_gain[%0d]: got %h expected %h", s, dut_gain(s), exp_gain[s]);
         end
      end
      vectors++;
      if (dones != 1) begin
         miscompares++;
         $display("[TB] FAIL sweep_done_count: got %0d expected 1", dones);
      end
      wait_req(GAP + 10, seen, ch, waited);
      vectors++;
      if (!seen || waited != int'(GAP) || ch !== 3'd1) begin
         miscompares++;
         $display("[TB] FAIL sweep_gap: got seen=%b delay=%0d chnl=%0d, expected delay=%0d chnl=1",
                  seen, waited + 1, ch, GAP + 1);
      end
   endtask

   task automatic test_timeout();
      bit seen, stable, last;
      logic [2:0] ch;
      logic [11:0] v;
      int waited;
      apply_reset();
      en = 1'b1;
      for (int s = 0; s < 6; s++) begin
         wait_req(4, seen, ch, waited);
         vectors++;
         if (!seen || ch !== POT_CH[s]) begin
            miscompares++;
            $display("[TB] FAIL timeout_req[%0d]: got seen=%b chnl=%0d, expected chnl=%0d",
                     s, seen, ch, POT_CH[s]);
            return;
         end
         v = 12'($urandom);
         respond((s == 3) ? 0 : int'($urandom_range(1, TMO)), v, stable);
         last = model_resolve(s != 3, v);
         vectors++;
         if (to_err !== exp_to_err || to_chnl !== exp_to_chnl || sweep_done !== last) begin
            miscompares++;
            $display("[TB] FAIL timeout_slot[%0d]: got to_err=%b to_chnl=%0d done=%b, expected %b %0d %b",
                     s, to_err, to_chnl, sweep_done, exp_to_err, exp_to_chnl, last);
         end
         if (s == 3) begin
            vectors++;
            if (gain_b3 !== 12'h800 || to_chnl !== 3'd2) begin
               miscompares++;
               $display("[TB] FAIL timeout_b3: got b3=%h to_chnl=%0d, expected 800 2", gain_b3, to_chnl);
            end
         end
      end
      for (int s = 0; s < 6; s++) begin
         vectors++;
         if (dut_gain(s) !== exp_gain[s]) begin
            miscompares++;
            $display("[TB] FAIL timeout_gain[%0d]: got %h expected %h", s, dut_gain(s), exp_gain[s]);
         end
      end
   endtask

   task automatic test_coincide();
      bit seen, stable, last;
      logic [2:0] ch;
      logic [11:0] v;
      int waited;
      apply_reset();
      en = 1'b1;
      for (int s = 0; s < 2; s++) begin
         wait_req(4, seen, ch, waited);
         v = 12'($urandom);
         respond(TMO, v, stable);
         last = model_resolve(1'b1, v);
         vectors++;
         if (!seen || dut_gain(s) !== exp_gain[s] || to_err !== 1'b0 || last) begin
            miscompares++;
            $display("[TB] FAIL coincide[%0d]: got seen=%b gain=%h to_err=%b, expected 1 %h 0",
                     s, seen, dut_gain(s), to_err, exp_gain[s]);
         end
      end
   endtask

   task automatic test_en_drop();
      bit seen, stable, last;
      logic [2:0] ch;
      logic [11:0] v;
      int waited, starts;
      apply_reset();
      en = 1'b1;
      for (int s = 0; s < 6; s++) begin
         wait_req(4, seen, ch, waited);
         vectors++;
         if (!seen || ch !== POT_CH[s] || waited != 0) begin
            miscompares++;
            $display("[TB] FAIL en_drop_req[%0d]: got seen=%b chnl=%0d wait=%0d, expected chnl=%0d wait=0",
                     s, seen, ch, waited, POT_CH[s]);
            return;
         end
         if (s == 2) en = 1'b0;
         v = 12'($urandom);
         respond($urandom_range(1, 12), v, stable);
         last = model_resolve(1'b1, v);
         vectors++;
         if (dut_gain(s) !== exp_gain[s] || sweep_done !== last || !stable) begin
            miscompares++;
            $display("[TB] FAIL en_drop_store[%0d]: got gain=%h done=%b stable=%b, expected %h %b 1",
                     s, dut_gain(s), sweep_done, stable, exp_gain[s], last);
         end
         if (s == 2) begin
            starts = 0;
            repeat (20) begin
               @(negedge clk);
               if (strt_cnv === 1'b1) starts++;
            end
            vectors++;
            if (starts != 0) begin
               miscompares++;
               $display("[TB] FAIL en_drop_hold: got %0d requests with en=0, expected 0", starts);
            end
            en = 1'b1;
         end
      end
   endtask

   task automatic test_rst_mid();
      bit seen, stable, last;
      logic [2:0] ch;
      int waited;
      apply_reset();
      en = 1'b1;
      for (int s = 0; s < 5; s++) begin
         wait_req(4, seen, ch, waited);
         respond($urandom_range(1, 5), 12'($urandom), stable);
         last = model_resolve(1'b1, 12'h000);
      end
      wait_req(4, seen, ch, waited);
      vectors++;
      if (!seen || ch !== 3'd7) begin
         miscompares++;
         $display("[TB] FAIL rst_mid_req: got seen=%b chnl=%0d, expected chnl=7", seen, ch);
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      model_reset();
      vectors++;
      if (volume !== 12'h800 || gain_lp !== 12'h800) begin
         miscompares++;
         $display("[TB] FAIL rst_mid_async: got vol=%h lp=%h, expected 800 800", volume, gain_lp);
      end
      @(negedge clk);
      rst       = 1'b0;
      cnv_cmplt = 1'b1;
      res       = 12'hFFF;
      @(negedge clk);
      cnv_cmplt = 1'b0;
      vectors++;
      if (strt_cnv !== 1'b1 || cnv_chnl !== 3'd1) begin
         miscompares++;
         $display("[TB] FAIL rst_mid_restart: got strt=%b chnl=%0d, expected 1 1", strt_cnv, cnv_chnl);
      end
      for (int s = 0; s < 6; s++) begin
         vectors++;
         if (dut_gain(s) !== exp_gain[s]) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_gain[%0d]: got %h expected %h", s, dut_gain(s), exp_gain[s]);
         end
      end
   endtask

   task automatic test_spurious();
      logic [11:0] v;
      bit last;
      apply_reset();
      repeat (8) begin
         @(negedge clk);
         cnv_cmplt = 1'b1;
         res       = 12'($urandom);
      end
      @(negedge clk);
      en  = 1'b1;
      res = 12'($urandom);
      @(negedge clk);
      res = 12'($urandom);
      vectors++;
      if (strt_cnv !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL spurious_req: got strt=%b expected 1", strt_cnv);
      end
      @(negedge clk);
      cnv_cmplt = 1'b0;
      for (int s = 0; s < 6; s++) begin
         vectors++;
         if (dut_gain(s) !== exp_gain[s]) begin
            miscompares++;
            $display("[TB] FAIL spurious_gain[%0d]: got %h expected %h", s, dut_gain(s), exp_gain[s]);
         end
      end
      v = 12'($urandom);
      repeat (3) @(negedge clk);
      cnv_cmplt = 1'b1;
      res       = v;
      @(negedge clk);
      cnv_cmplt = 1'b0;
      last = model_resolve(1'b1, v);
      vectors++;
      if (gain_lp !== exp_gain[0] || last) begin
         miscompares++;
         $display("[TB] FAIL spurious_then_real: got lp=%h expected %h", gain_lp, exp_gain[0]);
      end
   endtask

   task automatic test_random_sweeps();
      bit seen, stable, last, silent;
      logic [2:0] ch;
      logic [11:0] v;
      int waited, want_wait;
      apply_reset();
      en = 1'b1;
      for (int k = 0; k < 18; k++) begin
         want_wait = (k > 0 && exp_slot == 0) ? int'(GAP) : 0;
         wait_req(GAP + 10, seen, ch, waited);
         vectors++;
         if (!seen || ch !== POT_CH[exp_slot] || waited != want_wait) begin
            miscompares++;
            $display("[TB] FAIL random_req[%0d]: got seen=%b chnl=%0d wait=%0d, expected chnl=%0d wait=%0d",
                     k, seen, ch, waited, POT_CH[exp_slot], want_wait);
            return;
         end
         silent = ($urandom_range(0, 5) == 0);
         v = 12'($urandom);
         respond(silent ? 0 : int'($urandom_range(1, TMO)), v, stable);
         last = model_resolve(!silent, v);
         vectors++;
         if (!stable || sweep_done !== last || to_err !== exp_to_err || to_chnl !== exp_to_chnl) begin
            miscompares++;
            $display("[TB] FAIL random_slot[%0d]: got stable=%b done=%b to_err=%b to_chnl=%0d, expected 1 %b %b %0d",
                     k, stable, sweep_done, to_err, to_chnl, last, exp_to_err, exp_to_chnl);
         end
         for (int s = 0; s < 6; s++) begin
            vectors++;
            if (dut_gain(s) !== exp_gain[s]) begin
               miscompares++;
               $display("[TB] FAIL random_gain[%0d][%0d]: got %h expected %h", k, s, dut_gain(s), exp_gain[s]);
            end
         end
      end
   endtask

   task automatic test_zero_gap();
      bit found;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (sweep0 === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("[TB] FAIL zero_gap_done: got no sweep_done within 200 cycles, expected one");
         return;
      end
      @(negedge clk);
      vectors++;
      if (strt0 !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL zero_gap_idle: got strt=%b expected 0", strt0);
      end
      @(negedge clk);
      vectors++;
      if (strt0 !== 1'b1 || chnl0 !== 3'd1) begin
         miscompares++;
         $display("[TB] FAIL zero_gap_req: got strt=%b chnl=%0d, expected 1 1", strt0, chnl0);
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; en = 1'b0; cnv_cmplt = 1'b0; res = '0;
      test_reset();
      test_sweep();
      test_timeout();
      test_coincide();
      test_en_drop();
      test_rst_mid();
      test_spurious();
      test_random_sweeps();
      test_zero_gap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
